// File: rtl/bus_dec_ctl.sv
// bus_dec_ctl: registered bus address decoder and transaction controller.
// Latches a master request, drives a one-hot chip-select from the index
// field of the address, waits for the selected slave's ready and returns
// a one-cycle acknowledge with an error qualifier.
// Optional feature macro: BUS_DEC_TIMEOUT_EN -- when defined, an access
// that sees no ready for TO_CYC cycles is terminated with m_err=1.
module bus_dec_ctl #(
  parameter int AW      = 32,
  parameter int IDX_W   = 3,
  parameter int IDX_LSB = AW - IDX_W,
  parameter int TO_CYC  = 255,
  parameter int TO_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req,
  input  logic [AW-1:0]         m_addr,
  input  logic                  m_rw,
  output logic                  m_busy,
  output logic                  m_ack,
  output logic                  m_err,
  output logic [(2**IDX_W)-1:0] s_cs,
  output logic [AW-1:0]         s_addr,
  output logic                  s_rw,
  input  logic [(2**IDX_W)-1:0] s_rdy,
  input  logic [(2**IDX_W)-1:0] slv_en
);

  localparam int NSLV = 2**IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NSLV-1:0]   cs_q, cs_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  req_idx;
  logic              sel_rdy;

`ifdef BUS_DEC_TIMEOUT_EN
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              to_hit;
`endif

  assign req_idx = m_addr[IDX_LSB +: IDX_W];
  assign sel_rdy = s_rdy[idx_q];

`ifdef BUS_DEC_TIMEOUT_EN
  assign to_hit = (cnt_q == TO_W'(TO_CYC - 1));
`endif

  // Next-state and next-output decode for the transaction FSM.
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef BUS_DEC_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        cs_d = '0;
        if (m_req) begin
          addr_d = m_addr;
          rw_d   = m_rw;
          idx_d  = req_idx;
          if (slv_en[req_idx]) begin
            state_d       = ACCESS;
            cs_d[req_idx] = 1'b1;
`ifdef BUS_DEC_TIMEOUT_EN
            cnt_d         = '0;
`endif
          end else begin
            // Unpopulated slave: answer immediately with an error.
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        // Ready is checked before the timeout so a ready on the terminal
        // count still completes without error.
        if (sel_rdy) begin
          state_d = RESP;
          cs_d    = '0;
          ack_d   = 1'b1;
          err_d   = 1'b0;
`ifdef BUS_DEC_TIMEOUT_EN
        end else if (to_hit) begin
          state_d = RESP;
          cs_d    = '0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        cs_d    = '0;
      end
      default: begin
        state_d = IDLE;
        cs_d    = '0;
      end
    endcase
  end

  // State and registered outputs; async reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cs_q    <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef BUS_DEC_TIMEOUT_EN
  // Access timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign m_busy = (state_q != IDLE);
  assign m_ack  = ack_q;
  assign m_err  = err_q;
  assign s_cs   = cs_q;
  assign s_addr = addr_q;
  assign s_rw   = rw_q;

endmodule

// File: doc/bus_dec_ctl.md
# bus_dec_ctl

Parametrised, registered bus address decoder and transaction controller. Sits between the single bus master port and up to 2^IDX_W slave ports. It latches each master request and drives one-hot, registered chip-selects from the top IDX_W address bits. It holds the select until the addressed slave signals ready, then returns a one-cycle acknowledge, with an error flag for unpopulated slaves and timed-out accesses.

## Interface
Parameters:
- AW, 32, address width in bits
- IDX_W, 3, width of the slave index field; NSLV = 2**IDX_W slaves
- IDX_LSB, AW-IDX_W, bit position of the index field LSB; index = m_addr[IDX_LSB+IDX_W-1:IDX_LSB]
- TO_CYC, 255, timeout limit in cycles, 1..2**TO_W-1
- TO_W, 8, timeout counter width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_req  in  1  master request; sampled only in IDLE
- m_addr  in  AW  master address; valid with m_req
- m_rw  in  1  1 = write, 0 = read; valid with m_req
- m_busy  out  1  high while a transaction is in progress (state != IDLE)
- m_ack  out  1  one-cycle completion pulse
- m_err  out  1  error qualifier; high only in the m_ack cycle
- s_cs  out  NSLV  one-hot registered chip-selects
- s_addr  out  AW  latched request address
- s_rw  out  1  latched request direction
- s_rdy  in  NSLV  per-slave ready; only the selected bit is used
- slv_en  in  NSLV  populated-slave mask; sampled in IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - m_req=1 latches m_addr into s_addr, m_rw into s_rw, and the index into idx_q.
  - If slv_en[idx]=1: next state ACCESS, s_cs[idx] set to 1, timeout counter cleared to 0.
  - If slv_en[idx]=0: next state RESP with err_q=1; s_cs stays all-zero.
- ACCESS:
  - s_cs holds one-hot on idx_q.
  - If s_rdy[idx_q]=1: clear s_cs, err_q=0, go to RESP.
  - Otherwise the counter increments. Timeout rule is given under Configuration.
- RESP:
  - m_ack=1 for exactly one cycle; m_err=err_q.
  - Next state is always IDLE.
- m_req is ignored outside IDLE. A held m_req starts a new transaction on the first IDLE cycle after RESP.
- s_rdy bits of non-selected slaves are ignored in every state.
- s_cs is never multi-hot. s_cs is all-zero in IDLE and RESP.
- Reset (async, any state): state=IDLE, s_cs=0, s_addr=0, s_rw=0, m_ack=0, m_err=0, m_busy=0, counter=0. A transaction in flight at reset is aborted with no acknowledge.

## Timing
- All outputs are registered, except m_busy, which is decoded from state.
- Request accepted at edge 0 (IDLE, m_req=1). s_cs, s_addr and s_rw are valid after edge 0.
- Slave ready sampled at edge k (k>=1). m_ack is high from edge k to edge k+1, and s_cs drops after edge k. Minimum request-to-ack latency is 2 cycles, with zero slave wait states.
- Unpopulated slave: m_ack=1 and m_err=1 in the cycle after edge 0.
- Back-to-back requests: minimum 3 cycles per transaction (IDLE, ACCESS, RESP).
- s_rdy at the same edge as the timeout terminal count: ready wins; m_err=0.

## Configuration
- BUS_DEC_TIMEOUT_EN defined:
  - In ACCESS, when the counter equals TO_CYC-1 and s_rdy[idx_q]=0, clear s_cs, set err_q=1 and go to RESP.
  - The access is terminated after TO_CYC cycles of s_cs assertion.
- BUS_DEC_TIMEOUT_EN undefined:
  - The counter and the timeout logic are not built.
  - ACCESS waits indefinitely for s_rdy. m_err is raised only for unpopulated slaves.

## Test plan
- Reset mid-access: req to slave 2, assert rst_n=0 during ACCESS -> s_cs=0 and state IDLE immediately (async); no m_ack; first request after release behaves normally.
- Zero-wait read: slv_en=8'hFF, m_addr=32'h4000_0010, m_rw=0, s_rdy[2] tied 1 -> s_cs=8'h04 for 1 cycle, m_ack=1 and m_err=0 in the following cycle, s_addr=32'h4000_0010.
- Wait states: m_addr=32'hE000_0000, s_rdy[7] asserted 5 cycles after s_cs -> s_cs=8'h80 held 6 cycles, single m_ack, m_err=0; s_rdy[0]=1 throughout has no effect.
- Unpopulated slave: slv_en=8'h0F, m_addr=32'hA000_0000 -> s_cs stays 0, m_ack=1 and m_err=1 one cycle after request.
- Timeout (BUS_DEC_TIMEOUT_EN, TO_CYC=16): s_rdy never asserted -> s_cs high exactly 16 cycles, then m_ack=1, m_err=1. Without the macro, s_cs stays high for 1000 cycles with no ack.
- Busy overlap: m_req held high across two transactions with different addresses -> second address is ignored until after RESP; acks are 3 cycles apart with zero wait states.
